// File: rtl/game_pkg.sv
// Shared definitions for the game controller: state encoding, key codes and
// default parameter values.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam int unsigned KEY_W   = 2;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned SPEED_W = 4;

    localparam logic [KEY_W-1:0] KEY_NONE = 2'b00;
    localparam logic [KEY_W-1:0] KEY_JUMP = 2'b01;
    localparam logic [KEY_W-1:0] KEY_DUCK = 2'b10;

    localparam int unsigned DEBOUNCE_N_DEF = 4;
    localparam int unsigned SPEED_STEP_DEF = 100;
    localparam int unsigned MAX_SPEED_DEF  = 8;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a counter debouncer: the level flips only
// after DEBOUNCE_N consecutive synchronised samples disagree with it.
module key_debounce #(
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic myclk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int unsigned CNT_W = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_N - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge myclk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: debounced buttons, IDLE/RUN/OVER state machine, BCD score
// and scroll-speed level for the dino renderer and obstacle stage.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_N = DEBOUNCE_N_DEF,
    parameter int unsigned SPEED_STEP = SPEED_STEP_DEF,
    parameter int unsigned MAX_SPEED  = MAX_SPEED_DEF
) (
    input  logic               myclk,
    input  logic               rst,
    input  logic               btn_jump,
    input  logic               btn_duck,
    input  logic               frame_tick,
    input  logic               hit,
    output logic [KEY_W-1:0]   key,
    output logic               over,
    output logic               running,
    output logic [SCORE_W-1:0] score,
    output logic [SPEED_W-1:0] speed
);

    localparam int unsigned FRAME_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

    logic jump_lvl, duck_lvl, jump_press_c;

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 hit_q, hit_d;
    logic                 jump_prev_q, jump_prev_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 over_q, over_d;
    logic                 running_q, running_d;
    logic                 hit_now_c;

    key_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_jump (
        .myclk (myclk),
        .rst   (rst),
        .btn   (btn_jump),
        .level (jump_lvl)
    );

    key_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_duck (
        .myclk (myclk),
        .rst   (rst),
        .btn   (btn_duck),
        .level (duck_lvl)
    );

    // Four-digit BCD increment that sticks at 9999.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign jump_press_c = jump_lvl & ~jump_prev_q;
    assign hit_now_c    = hit_q | hit;

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        speed_d     = speed_q;
        frame_d     = frame_q;
        hit_d       = hit_q;
        jump_prev_d = jump_lvl;
        unique case (state_q)
            IDLE, OVER: begin
                if (jump_press_c) begin
                    state_d = RUN;
                    score_d = '0;
                    speed_d = SPEED_W'(1);
                    frame_d = '0;
                    hit_d   = 1'b0;
                end
            end
            RUN: begin
                hit_d = hit_now_c;
                // A collision anywhere in the frame ends the game at its tick.
                if (frame_tick) begin
                    if (hit_now_c) begin
                        state_d = OVER;
                    end else begin
                        score_d = bcd_inc(score_q);
                        if (frame_q == FRAME_W'(SPEED_STEP - 1)) begin
                            frame_d = '0;
                            if (speed_q < SPEED_W'(MAX_SPEED)) begin
                                speed_d = speed_q + SPEED_W'(1);
                            end
                        end else begin
                            frame_d = frame_q + FRAME_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Key follows the debounced levels only while the next state is RUN.
        key_d = KEY_NONE;
        if (state_d == RUN) begin
            if (jump_lvl) begin
                key_d = KEY_JUMP;
            end else if (duck_lvl) begin
                key_d = KEY_DUCK;
            end
        end
        running_d = (state_d == RUN);
        over_d    = (state_d == OVER);
    end

    always_ff @(posedge myclk) begin
        if (rst) begin
            state_q     <= IDLE;
            score_q     <= '0;
            speed_q     <= SPEED_W'(1);
            frame_q     <= '0;
            hit_q       <= 1'b0;
            jump_prev_q <= 1'b0;
            key_q       <= KEY_NONE;
            over_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            speed_q     <= speed_d;
            frame_q     <= frame_d;
            hit_q       <= hit_d;
            jump_prev_q <= jump_prev_d;
            key_q       <= key_d;
            over_q      <= over_d;
            running_q   <= running_d;
        end
    end

    assign key     = key_q;
    assign over    = over_q;
    assign running = running_q;
    assign score   = score_q;
    assign speed   = speed_q;

endmodule
